// File: rtl/pe_net_seq_ctrl.sv
// Job sequencer for the PE_net array: weight load, one-cycle control configuration,
// one frame of pixel beats under valid/ready, then a fixed drain with a done pulse.
module pe_net_seq_ctrl #(
    parameter int unsigned ROW_SIZE  = 4,
    parameter int unsigned N         = 4,
    parameter int unsigned M         = 2,
    parameter int unsigned CL_IN     = 4,
    parameter int unsigned CL1       = 2,
    parameter int unsigned LINES     = 16,
    parameter int unsigned W_CYC     = 9,
    parameter int unsigned DRAIN_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [ROW_SIZE*M-1:0]     w_data,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [ROW_SIZE*CL_IN-1:0] cfg_d_ch,
    input  logic [ROW_SIZE*CL_IN-1:0] cfg_bp_ch,
    input  logic [ROW_SIZE*CL1-1:0]   cfg_bp_src,
    input  logic [ROW_SIZE*N-1:0]     src_data,
    input  logic                      src_valid,
    output logic                      src_ready,
    output logic [ROW_SIZE*N-1:0]     net_d_in,
    output logic [ROW_SIZE-1:0]       net_en_in,
    output logic [ROW_SIZE*M-1:0]     net_w_in,
    output logic                      net_w_conf,
    output logic                      net_cntl_conf,
    output logic [ROW_SIZE*CL_IN-1:0] net_d_ch,
    output logic [ROW_SIZE*CL_IN-1:0] net_bp_ch,
    output logic [ROW_SIZE*CL1-1:0]   net_bp_src,
    input  logic [ROW_SIZE-1:0]       net_en_out,
    output logic [15:0]               res_cnt
);

    localparam int unsigned FRAME   = LINES * LINES;
    localparam int unsigned W_CNT_W = (W_CYC > 1) ? $clog2(W_CYC) : 1;
    localparam int unsigned B_CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int unsigned D_CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [W_CNT_W-1:0] W_LAST = W_CNT_W'(W_CYC - 1);
    localparam logic [B_CNT_W-1:0] B_LAST = B_CNT_W'(FRAME - 1);
    localparam logic [D_CNT_W-1:0] D_LAST = D_CNT_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StConf,
        StRun,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [W_CNT_W-1:0] w_cnt_q, w_cnt_d;
    logic [B_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [D_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               done_q, done_d;
    logic [15:0]        res_cnt_q, res_cnt_d;

    logic [ROW_SIZE*N-1:0]     net_d_in_q;
    logic [ROW_SIZE-1:0]       net_en_in_q;
    logic [ROW_SIZE*M-1:0]     net_w_in_q;
    logic                      net_w_conf_q;
    logic                      net_cntl_conf_q;
    logic [ROW_SIZE*CL_IN-1:0] net_d_ch_q;
    logic [ROW_SIZE*CL_IN-1:0] net_bp_ch_q;
    logic [ROW_SIZE*CL1-1:0]   net_bp_src_q;

    logic job_start;
    logic w_accept;
    logic src_accept;

    // Only bit 0 of the array output enables drives the result counter.
    logic unused_en_out;
    assign unused_en_out = ^net_en_out;

    // Readies are pure state decodes so there is no valid->ready combinational path.
    assign busy       = (state_q != StIdle);
    assign w_ready    = (state_q == StLoadW);
    assign src_ready  = (state_q == StRun);
    assign job_start  = (state_q == StIdle) && start;
    assign w_accept   = w_ready && w_valid;
    assign src_accept = src_ready && src_valid;

    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoadW;
                    w_cnt_d     = '0;
                    beat_cnt_d  = '0;
                    drain_cnt_d = '0;
                end
            end
            StLoadW: begin
                if (w_valid) begin
                    if (w_cnt_q == W_LAST) begin
                        state_d = StConf;
                        w_cnt_d = '0;
                    end else begin
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
            end
            StConf: begin
                state_d = StRun;
            end
            StRun: begin
                if (src_valid) begin
                    if (beat_cnt_q == B_LAST) begin
                        state_d    = StDrain;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (drain_cnt_q == D_LAST) begin
                    state_d     = StIdle;
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        res_cnt_d = res_cnt_q;
        if (job_start) begin
            res_cnt_d = '0;
        end else if (busy && net_en_out[0] && (res_cnt_q != 16'hFFFF)) begin
            res_cnt_d = res_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            w_cnt_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    // Array-facing registers: data holds across bubbles, strobes fall to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            net_d_in_q      <= '0;
            net_en_in_q     <= '0;
            net_w_in_q      <= '0;
            net_w_conf_q    <= 1'b0;
            net_cntl_conf_q <= 1'b0;
            net_d_ch_q      <= '0;
            net_bp_ch_q     <= '0;
            net_bp_src_q    <= '0;
        end else begin
            net_w_conf_q    <= w_accept;
            net_cntl_conf_q <= (state_q == StConf);
            net_en_in_q     <= {ROW_SIZE{src_accept}};
            if (w_accept) begin
                net_w_in_q <= w_data;
            end
            if (src_accept) begin
                net_d_in_q <= src_data;
            end
            if (job_start) begin
                net_d_ch_q   <= cfg_d_ch;
                net_bp_ch_q  <= cfg_bp_ch;
                net_bp_src_q <= cfg_bp_src;
            end
        end
    end

    assign done          = done_q;
    assign res_cnt       = res_cnt_q;
    assign net_d_in      = net_d_in_q;
    assign net_en_in     = net_en_in_q;
    assign net_w_in      = net_w_in_q;
    assign net_w_conf    = net_w_conf_q;
    assign net_cntl_conf = net_cntl_conf_q;
    assign net_d_ch      = net_d_ch_q;
    assign net_bp_ch     = net_bp_ch_q;
    assign net_bp_src    = net_bp_src_q;

endmodule
